uart_tx_arbiter: RTL and testbench

Message-level round-robin arbiter that shares the single UART transmit path (FIFO write port of the UART TX top) between NUM_REQ byte-stream clients.
- Each client streams bytes with valid/ready and marks the final byte of a message with last.
- The arbiter holds the grant for one whole message, so messages are never interleaved on the serial line.
- Stalled or runaway clients are evicted by an idle timeout and a maximum message length.

---
 rtl/uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Message-level round-robin arbiter sharing the UART TX FIFO write port
// between NUM_REQ byte-stream clients. A grant is held for one whole message,
// so messages are never interleaved on the serial line. A granted client is
// evicted if it holds valid low for IDLE_TIMEOUT cycles, and a message is
// truncated after MAX_LEN bytes. The remaining bytes are arbitrated again
// later as a new message.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-client byte valid
//   req_data   per-client byte, client i at [i*DATA_BITS +: DATA_BITS]
//   req_last   per-client end-of-message flag (qualified by req_valid)
//   req_ready  per-client accept, at most one bit set
//   tx_wr_en   UART TX FIFO write strobe
//   tx_d_in    UART TX FIFO write data
//   tx_full    UART TX FIFO full
//   grant      registered one-hot grant, zero when idle
//   busy       high while a message is being transferred
//   abort      one-cycle pulse: client evicted by idle timeout
//   len_err    one-cycle pulse: client message truncated at MAX_LEN
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int MAX_LEN      = 64,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_wr_en,
    output logic [DATA_BITS-1:0]           tx_d_in,
    input  logic                           tx_full,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [NUM_REQ-1:0]             abort,
    output logic [NUM_REQ-1:0]             len_err
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int SUM_W  = IDX_W + 1;
    localparam int BCNT_W = $clog2(MAX_LEN + 1);
    localparam int ICNT_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Round-robin successor of a client index (NUM_REQ need not be a power of 2).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            res = '0;
        end else begin
            res = idx + 1'b1;
        end
        return res;
    endfunction

    logic [0:0]           state_q,   state_d;
    logic [NUM_REQ-1:0]   grant_q,   grant_d;
    logic [IDX_W-1:0]     gidx_q,    gidx_d;
    logic [IDX_W-1:0]     ptr_q,     ptr_d;
    logic [BCNT_W-1:0]    bcnt_q,    bcnt_d;
    logic [ICNT_W-1:0]    icnt_q,    icnt_d;
    logic [NUM_REQ-1:0]   abort_q,   abort_d;
    logic [NUM_REQ-1:0]   len_err_q, len_err_d;

    logic                 xfer_s;
    logic                 sel_valid_s;
    logic                 sel_last_s;
    logic [DATA_BITS-1:0] sel_data_s;
    logic                 fire_s;
    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [SUM_W-1:0]     scan_sum_s;
    logic [IDX_W-1:0]     scan_idx_s;

    assign xfer_s      = (state_q == ST_XFER);
    assign sel_valid_s = req_valid[gidx_q];
    assign sel_last_s  = req_last[gidx_q];

    // Byte mux: slice of the currently granted client.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = (gidx_q == IDX_W'(i)) ? req_data[i*DATA_BITS +: DATA_BITS] : sel_data_s;
        end
    end

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        scan_sum_s   = '0;
        scan_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum_s = {1'b0, ptr_q} + SUM_W'(k);
            if (scan_sum_s >= SUM_W'(NUM_REQ)) begin
                scan_sum_s = scan_sum_s - SUM_W'(NUM_REQ);
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = scan_sum_s[IDX_W-1:0];
            if (!pick_found_s && req_valid[scan_idx_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = scan_idx_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // FIFO-side handshake; ready ignores valid so a stalled FIFO never looks
    // like a misbehaving client.
    assign req_ready = (xfer_s && !tx_full) ? grant_q : '0;
    assign tx_wr_en  = xfer_s & sel_valid_s & ~tx_full;
    assign tx_d_in   = sel_data_s;
    assign fire_s    = tx_wr_en;

    assign grant   = grant_q;
    assign busy    = xfer_s;
    assign abort   = abort_q;
    assign len_err = len_err_q;

    // Next-state logic: grant, release, message length and idle eviction.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        icnt_d    = icnt_q;
        abort_d   = '0;
        len_err_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_XFER;
                    gidx_d  = pick_idx_s;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    bcnt_d  = '0;
                    icnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (fire_s) begin
                    bcnt_d = bcnt_q + 1'b1;
                    icnt_d = '0;
                    // Release on the client's last byte or on byte MAX_LEN.
                    if (sel_last_s || (bcnt_q == BCNT_W'(MAX_LEN - 1))) begin
                        state_d   = ST_IDLE;
                        grant_d   = '0;
                        ptr_d     = next_idx(gidx_q);
                        len_err_d = sel_last_s ? '0 : grant_q;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (!sel_valid_s) begin
                    icnt_d = icnt_q + 1'b1;
                    if (icnt_q == ICNT_W'(IDLE_TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = next_idx(gidx_q);
                        abort_d = grant_q;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    // Valid held against a full FIFO: idle counter holds.
                    icnt_d = icnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            bcnt_q    <= '0;
            icnt_q    <= '0;
            abort_q   <= '0;
            len_err_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            bcnt_q    <= bcnt_d;
            icnt_q    <= icnt_d;
            abort_q   <= abort_d;
            len_err_q <= len_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a message-level reference model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;
    localparam int ML = 4;
    localparam int IT = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR*DB-1:0]   req_data;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      req_ready;
    logic               tx_wr_en;
    logic [DB-1:0]      tx_d_in;
    logic               tx_full;
    logic [NR-1:0]      grant;
    logic               busy;
    logic [NR-1:0]      abort;
    logic [NR-1:0]      len_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .MAX_LEN(ML), .IDLE_TIMEOUT(IT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_wr_en(tx_wr_en),
        .tx_d_in(tx_d_in), .tx_full(tx_full), .grant(grant), .busy(busy),
        .abort(abort), .len_err(len_err)
    );

    // client byte queues: {last, data}
    logic [8:0] cmem [NR][256];
    int chead [NR];
    int ctail [NR];
    int avail [NR];
    int force_gap [NR];
    int cyc;
    logic full_r;
    bit rand_gaps;

    // reference model state
    int owner;
    int ptr;
    int nbytes;
    int idlec;
    logic [NR-1:0] exp_abort;
    logic [NR-1:0] exp_len;
    logic [NR-1:0] s_valid;
    logic [NR-1:0] s_last;
    int s_fire;

    // observed FIFO writes and pulses
    int wl_data [$];
    int wl_cyc [$];
    int wl_cli [$];
    int abort_cnt [NR];
    int abort_cyc [NR];
    int len_cnt [NR];
    int len_cyc [NR];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_byte(input int c, input logic [7:0] d, input bit last);
        cmem[c][ctail[c] % 256] = {last, d};
        ctail[c]++;
    endtask

    task automatic push_msg(input int c, input int len);
        for (int k = 0; k < len; k++) begin
            push_byte(c, 8'($urandom_range(0, 255)), (k == len - 1));
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (ctail[i] != chead[i] && cyc >= avail[i]) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = cmem[i][chead[i] % 256][8];
                req_data[i*DB +: DB] = cmem[i][chead[i] % 256][7:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*DB +: DB] = 8'h00;
            end
        end
        tx_full = full_r;
    endtask

    task automatic check_outputs();
        logic [NR-1:0] one;
        logic [NR-1:0] expg;
        logic exp_wr;
        int cli;
        one = 1;
        s_valid = req_valid;
        s_last  = req_last;
        expg    = (owner >= 0) ? (one << owner) : '0;
        exp_wr  = (owner >= 0) && s_valid[owner] && !full_r;
        chk("grant", 32'(grant), 32'(expg));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("req_ready", 32'(req_ready), (owner >= 0 && !full_r) ? 32'(expg) : 32'd0);
        chk("tx_wr_en", 32'(tx_wr_en), 32'(exp_wr));
        chk("abort", 32'(abort), 32'(exp_abort));
        chk("len_err", 32'(len_err), 32'(exp_len));
        if (exp_wr) begin
            chk("tx_d_in", 32'(tx_d_in), 32'(cmem[owner][chead[owner] % 256][7:0]));
        end
        s_fire = exp_wr ? owner : -1;
        if (tx_wr_en) begin
            cli = -1;
            for (int i = 0; i < NR; i++) if (req_ready[i]) cli = i;
            wl_data.push_back(int'(tx_d_in));
            wl_cyc.push_back(cyc);
            wl_cli.push_back(cli);
        end
        for (int i = 0; i < NR; i++) begin
            if (abort[i])   begin abort_cnt[i]++; abort_cyc[i] = cyc; end
            if (len_err[i]) begin len_cnt[i]++;   len_cyc[i]   = cyc; end
        end
    endtask

    task automatic pop_client(input int c);
        int gap;
        chead[c]++;
        if (force_gap[c] >= 0) gap = force_gap[c];
        else if (rand_gaps && $urandom_range(0, 7) == 0) gap = $urandom_range(1, 6);
        else gap = 0;
        force_gap[c] = -1;
        avail[c] = cyc + 1 + gap;
    endtask

    // Message-level behaviour: who owns the FIFO, when a message ends, when
    // a client is thrown out.
    task automatic update_model();
        bit found;
        bit lastb;
        int j;
        exp_abort = '0;
        exp_len   = '0;
        if (owner < 0) begin
            found = 0;
            for (int k = 0; k < NR; k++) begin
                j = (ptr + k) % NR;
                if (!found && s_valid[j]) begin
                    found = 1; owner = j; nbytes = 0; idlec = 0;
                end
            end
        end else if (s_fire >= 0) begin
            lastb = s_last[owner];
            pop_client(owner);
            nbytes++;
            idlec = 0;
            if (lastb || nbytes == ML) begin
                if (!lastb) exp_len[owner] = 1'b1;
                ptr = (owner + 1) % NR;
                owner = -1;
            end
        end else if (!s_valid[owner]) begin
            idlec++;
            if (idlec == IT) begin
                exp_abort[owner] = 1'b1;
                ptr = (owner + 1) % NR;
                owner = -1;
            end
        end
        cyc++;
    endtask

    task automatic model_reset();
        owner = -1; ptr = 0; nbytes = 0; idlec = 0;
        exp_abort = '0; exp_len = '0;
    endtask

    task automatic tick();
        drive_inputs();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = (owner >= 0) || (exp_abort != '0) || (exp_len != '0);
        for (int i = 0; i < NR; i++) if (ctail[i] != chead[i]) p = 1;
        return p;
    endfunction

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while (pending() && n < bound) begin tick(); n++; end
        if (pending()) chk("drain_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic wait_writes(input int cnt, input int bound);
        int n;
        n = 0;
        while (wl_data.size() < cnt && n < bound) begin tick(); n++; end
        if (wl_data.size() < cnt) chk("wait_writes_timeout", 32'(wl_data.size()), 32'(cnt));
    endtask

    task automatic clear_log();
        wl_data.delete(); wl_cyc.delete(); wl_cli.delete();
    endtask

    initial begin
        int t0;
        int ab0;
        int le0;
        logic [7:0] exp_b [6];

        for (int i = 0; i < NR; i++) begin
            chead[i] = 0; ctail[i] = 0; avail[i] = 0; force_gap[i] = -1;
            abort_cnt[i] = 0; abort_cyc[i] = 0; len_cnt[i] = 0; len_cyc[i] = 0;
        end
        cyc = 0; full_r = 1'b0; rand_gaps = 0; s_fire = -1;
        model_reset();

        // reset values, with every client requesting
        rst_n = 1'b0; req_valid = '1; req_last = '0; req_data = '0; tx_full = 1'b0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(tx_wr_en), 32'd0);
        req_valid = '0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // contention: clients 0 and 2 from the same cycle
        clear_log();
        push_byte(0, 8'hA0, 0); push_byte(0, 8'hA1, 1);
        push_byte(2, 8'hC0, 0); push_byte(2, 8'hC1, 1);
        run_until_idle(50);
        chk("t2_count", 32'(wl_data.size()), 32'd4);
        if (wl_data.size() == 4) begin
            chk("t2_b0", 32'(wl_data[0]), 32'hA0);
            chk("t2_b1", 32'(wl_data[1]), 32'hA1);
            chk("t2_b2", 32'(wl_data[2]), 32'hC0);
            chk("t2_b3", 32'(wl_data[3]), 32'hC1);
            chk("t2_dead_cycle", 32'(wl_cyc[2] - wl_cyc[1]), 32'd2);
        end

        // single client, three bytes
        clear_log();
        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h43, 1);
        t0 = cyc;
        run_until_idle(50);
        chk("t1_count", 32'(wl_data.size()), 32'd3);
        if (wl_data.size() == 3) begin
            chk("t1_latency", 32'(wl_cyc[0]), 32'(t0 + 1));
            chk("t1_back_to_back", 32'(wl_cyc[2] - wl_cyc[0]), 32'd2);
            chk("t1_b0", 32'(wl_data[0]), 32'h41);
            chk("t1_b2", 32'(wl_data[2]), 32'h43);
        end
        // pointer now at 1: client 1 wins over client 0
        clear_log();
        push_byte(0, 8'h01, 1); push_byte(1, 8'h02, 1);
        run_until_idle(50);
        if (wl_cli.size() == 2) begin
            chk("t1_ptr_first", 32'(wl_cli[0]), 32'd1);
            chk("t1_ptr_second", 32'(wl_cli[1]), 32'd0);
        end else chk("t1_ptr_count", 32'(wl_cli.size()), 32'd2);

        // backpressure longer than the idle timeout
        clear_log();
        ab0 = abort_cnt[1];
        push_byte(1, 8'h10, 0); push_byte(1, 8'h11, 0); push_byte(1, 8'h12, 1);
        wait_writes(1, 20);
        full_r = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        full_r = 1'b0;
        run_until_idle(50);
        chk("t3_count", 32'(wl_data.size()), 32'd3);
        if (wl_data.size() == 3) begin
            chk("t3_b1", 32'(wl_data[1]), 32'h11);
            chk("t3_b2", 32'(wl_data[2]), 32'h12);
        end
        chk("t3_no_abort", 32'(abort_cnt[1] - ab0), 32'd0);

        // idle timeout: client 1 stalls after one byte, client 2 waits
        clear_log();
        ab0 = abort_cnt[1];
        force_gap[1] = 20;
        push_byte(1, 8'h20, 0); push_byte(1, 8'h21, 1);
        wait_writes(1, 20);
        push_byte(2, 8'h30, 1);
        run_until_idle(100);
        chk("t4_abort_cnt", 32'(abort_cnt[1] - ab0), 32'd1);
        if (wl_data.size() == 3) begin
            chk("t4_abort_time", 32'(abort_cyc[1] - wl_cyc[0]), 32'(IT + 1));
            chk("t4_next_client", 32'(wl_cli[1]), 32'd2);
            chk("t4_next_byte", 32'(wl_data[1]), 32'h30);
            chk("t4_rest_byte", 32'(wl_data[2]), 32'h21);
        end else chk("t4_count", 32'(wl_data.size()), 32'd3);

        // length limit: six bytes from client 3
        clear_log();
        le0 = len_cnt[3];
        for (int k = 0; k < 6; k++) begin
            exp_b[k] = 8'(8'h50 + k);
            push_byte(3, exp_b[k], (k == 5));
        end
        run_until_idle(100);
        chk("t5_len_err_cnt", 32'(len_cnt[3] - le0), 32'd1);
        chk("t5_count", 32'(wl_data.size()), 32'd6);
        if (wl_data.size() == 6) begin
            chk("t5_len_err_time", 32'(len_cyc[3]), 32'(wl_cyc[3] + 1));
            chk("t5_regrant_gap", 32'(wl_cyc[4] - wl_cyc[3]), 32'd2);
            for (int k = 0; k < 6; k++) chk("t5_byte", 32'(wl_data[k]), 32'(exp_b[k]));
        end

        // reset mid-message restarts round-robin from client 0
        push_byte(0, 8'h0F, 1);
        run_until_idle(50);
        clear_log();
        for (int k = 0; k < 5; k++) push_byte(1, 8'(8'h60 + k), (k == 4));
        wait_writes(1, 20);
        push_byte(0, 8'h70, 1); push_byte(2, 8'h72, 1);
        drive_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_grant_async", 32'(grant), 32'd0);
        chk("t6_busy_async", 32'(busy), 32'd0);
        chk("t6_wr_en_async", 32'(tx_wr_en), 32'd0);
        model_reset();
        @(negedge clk); check_outputs();
        @(posedge clk); cyc++; #1;
        drive_inputs();
        @(negedge clk); check_outputs();
        clear_log();
        #1 rst_n = 1'b1;
        @(posedge clk); update_model(); #1;
        run_until_idle(100);
        if (wl_cli.size() == 6) begin
            chk("t6_first_client", 32'(wl_cli[0]), 32'd0);
            chk("t6_second_client", 32'(wl_cli[1]), 32'd1);
            chk("t6_resume_byte", 32'(wl_data[1]), 32'h61);
        end else chk("t6_count", 32'(wl_cli.size()), 32'd6);

        // randomized traffic
        rand_gaps = 1;
        for (int n = 0; n < 1500; n++) begin
            full_r = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NR; i++) begin
                if ((ctail[i] - chead[i]) < 200 && $urandom_range(0, 19) == 0)
                    push_msg(i, $urandom_range(1, 7));
            end
            tick();
        end
        full_r = 1'b0;
        run_until_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
